// File: rtl/cmp_nibble_serial_pkg.sv
// Shared types and helpers for the nibble-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 4-bit slices in an operand of the given width.
  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/cmp_nibble_serial_if.sv
// Operand-in / result-out handshake bundle for cmp_nibble_serial.
interface cmp_nibble_serial_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(cmp_pkg::nib_count(WIDTH) + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CW-1:0]    depth;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, gt, lt, depth
  );

  // The comparator itself
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, gt, lt, depth
  );
endinterface

// File: rtl/cmp_nibble_serial_comparator_4bit.sv
// Purely combinational 4-bit unsigned magnitude compare.
module comparator_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       eq_o,
  output logic       gt_o,
  output logic       lt_o
);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);
endmodule

// File: rtl/cmp_nibble_serial.sv
// Multi-cycle unsigned magnitude comparator: walks the operands one nibble
// per cycle from the MSB end and stops at the first differing nibble.
module cmp_nibble_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  cmp_nibble_serial_if.slave bus
);
  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = $clog2(NIB + 1);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_chk
    $error("cmp_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // Result of the last slice compared; both low means the operands matched.
  logic                  rgt_q, rgt_d, rlt_q, rlt_d;
  logic                  ov_q, ov_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [CW-1:0]         dep_q, dep_d;

  logic                  sl_eq, sl_gt, sl_lt;
  logic                  last_slice;

  assign last_slice = (idx_q == '0);

  comparator_4bit u_cmp4 (
    .a_i  (a_q[idx_q]),
    .b_i  (b_q[idx_q]),
    .eq_o (sl_eq),
    .gt_o (sl_gt),
    .lt_o (sl_lt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave CMP on first mismatch or after the LSB slice;
  // leave DONE only once the visible result has been taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)                state_d = CMP;
      CMP:     if (!sl_eq || last_slice)        state_d = DONE;
      DONE:    if (ov_q && bus.out_ready)       state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Datapath / output next-values. DONE spends one cycle publishing the
  // latched slice result before it becomes visible, so out_valid is never
  // high without a consistent eq/gt/lt/depth set.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rgt_d = rgt_q;
    rlt_d = rlt_q;
    ov_d  = ov_q;
    eq_d  = eq_q;
    gt_d  = gt_q;
    lt_d  = lt_q;
    dep_d = dep_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.a;
          b_d   = bus.b;
          idx_d = IW'(NIB - 1);
          cnt_d = '0;
        end
      end
      CMP: begin
        cnt_d = cnt_q + CW'(1);
        rgt_d = sl_gt;
        rlt_d = sl_lt;
        if (sl_eq && !last_slice) idx_d = idx_q - IW'(1);
      end
      DONE: begin
        if (!ov_q) begin
          ov_d  = 1'b1;
          eq_d  = ~(rgt_q | rlt_q);
          gt_d  = rgt_q;
          lt_d  = rlt_q;
          dep_d = cnt_q;
        end else if (bus.out_ready) begin
          ov_d  = 1'b0;
          eq_d  = 1'b0;
          gt_d  = 1'b0;
          lt_d  = 1'b0;
          dep_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Operand, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      rgt_q <= 1'b0;
      rlt_q <= 1'b0;
      ov_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      dep_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rgt_q <= rgt_d;
      rlt_q <= rlt_d;
      ov_q  <= ov_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      dep_q <= dep_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.depth     = dep_q;

endmodule

// File: tb/tb_cmp_nibble_serial.sv
// Directed-vector and random bench for cmp_nibble_serial at WIDTH 4/16/32.
module tb_cmp_nibble_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_nibble_serial_if #(.WIDTH(4))  if4  ();
  cmp_nibble_serial_if #(.WIDTH(16)) if16 ();
  cmp_nibble_serial_if #(.WIDTH(32)) if32 ();

  cmp_nibble_serial #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
  cmp_nibble_serial #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
  cmp_nibble_serial #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slices examined from the MSB end up to and including the first difference.
  function automatic int exp_depth(input logic [63:0] a, input logic [63:0] b, input int nib);
    for (int i = nib - 1; i >= 0; i--)
      if (((a >> (4 * i)) & 64'hF) != ((b >> (4 * i)) & 64'hF)) return nib - i;
    return nib;
  endfunction

  // Invariants on every cycle outside reset
  task automatic inv(input string nm, input logic ov, input logic eq, input logic gt,
                     input logic lt, input int dep, input int nib);
    if (ov) begin
      chk({nm, " onehot"}, 64'($onehot({eq, gt, lt})), 64'd1);
      chk({nm, " depth range"}, 64'((dep >= 1) && (dep <= nib)), 64'd1);
    end else begin
      chk({nm, " idle outputs"}, {59'd0, eq, gt, lt, 2'b00} | 64'(dep), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      inv("u4",  if4.out_valid,  if4.eq,  if4.gt,  if4.lt,  int'(if4.depth),  1);
      inv("u16", if16.out_valid, if16.eq, if16.gt, if16.lt, int'(if16.depth), 4);
      inv("u32", if32.out_valid, if32.eq, if32.gt, if32.lt, int'(if32.depth), 8);
    end
  end

  // Called just after the accept edge; returns at the negedge where out_valid is seen.
  task automatic wait_res16(input string nm, input logic eq, input logic gt, input logic lt,
                            input int dep, input int lat_exp);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if16.out_valid) seen = 1;
    end
    chk({nm, " timeout"}, 64'(seen), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(lat_exp));
    chk({nm, " eq"}, 64'(if16.eq), 64'(eq));
    chk({nm, " gt"}, 64'(if16.gt), 64'(gt));
    chk({nm, " lt"}, 64'(if16.lt), 64'(lt));
    chk({nm, " depth"}, 64'(if16.depth), 64'(dep));
  endtask

  // Full transaction with out_ready held high: result must be visible one cycle.
  task automatic txn16(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic eq, input logic gt, input logic lt, input int dep,
                       input int lat_exp);
    @(negedge clk);
    chk({nm, " in_ready"}, 64'(if16.in_ready), 64'd1);
    if16.in_valid  = 1'b1;
    if16.a         = a;
    if16.b         = b;
    if16.out_ready = 1'b1;
    @(posedge clk);
    #1 if16.in_valid = 1'b0;
    wait_res16(nm, eq, gt, lt, dep, lat_exp);
    @(negedge clk);
    chk({nm, " one-cycle valid"}, 64'(if16.out_valid), 64'd0);
    chk({nm, " cleared depth"}, 64'(if16.depth), 64'd0);
  endtask

  task automatic rnd4(input logic [3:0] a, input logic [3:0] b);
    int lat;
    bit seen;
    int stall;
    @(negedge clk);
    chk("r4 in_ready", 64'(if4.in_ready), 64'd1);
    if4.in_valid = 1'b1;
    if4.a = a;
    if4.b = b;
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if4.out_valid) seen = 1;
      else if4.out_ready = 1'($urandom_range(0, 1));
    end
    chk("r4 timeout", 64'(seen), 64'd1);
    chk("r4 latency", 64'(lat), 64'd2);
    chk("r4 res", {61'd0, if4.eq, if4.gt, if4.lt}, {61'd0, a == b, a > b, a < b});
    chk("r4 depth", 64'(if4.depth), 64'd1);
    if4.out_ready = 1'b0;
    stall = $urandom_range(0, 3);
    repeat (stall) begin
      @(negedge clk);
      chk("r4 hold", {60'd0, if4.out_valid, if4.eq, if4.gt, if4.lt}, {60'd0, 1'b1, a == b, a > b, a < b});
    end
    if4.out_ready = 1'b1;
    @(negedge clk);
    chk("r4 drop", 64'(if4.out_valid), 64'd0);
    if4.out_ready = 1'b0;
  endtask

  task automatic rnd32(input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit seen;
    int stall;
    int d;
    d = exp_depth(64'(a), 64'(b), 8);
    @(negedge clk);
    chk("r32 in_ready", 64'(if32.in_ready), 64'd1);
    if32.in_valid = 1'b1;
    if32.a = a;
    if32.b = b;
    @(posedge clk);
    #1 if32.in_valid = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (if32.out_valid) seen = 1;
      else if32.out_ready = 1'($urandom_range(0, 1));
    end
    chk("r32 timeout", 64'(seen), 64'd1);
    chk("r32 latency", 64'(lat), 64'(d + 1));
    chk("r32 res", {61'd0, if32.eq, if32.gt, if32.lt}, {61'd0, a == b, a > b, a < b});
    chk("r32 depth", 64'(if32.depth), 64'(d));
    if32.out_ready = 1'b0;
    stall = $urandom_range(0, 3);
    repeat (stall) begin
      @(negedge clk);
      chk("r32 hold", 64'(if32.depth) | (64'(if32.out_valid) << 8), 64'(d) | (64'd1 << 8));
    end
    if32.out_ready = 1'b1;
    @(negedge clk);
    chk("r32 drop", 64'(if32.out_valid), 64'd0);
    if32.out_ready = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic        eq;
    logic        gt;
    logic        lt;
    int          dep;
    int          lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{"eq_1234",    16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 4, 5};
    vt[1] = '{"gt_msb",     16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1, 2};
    vt[2] = '{"lt_slice1",  16'h12A4, 16'h12B4, 1'b0, 1'b0, 1'b1, 3, 4};
    vt[3] = '{"eq_zero",    16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 5};
    vt[4] = '{"gt_lsb",     16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0, 4, 5};
    vt[5] = '{"lt_slice2",  16'h0001, 16'h0100, 1'b0, 1'b0, 1'b1, 2, 3};
    vt[6] = '{"gt_msb2",    16'hABCD, 16'h0BCD, 1'b0, 1'b1, 1'b0, 1, 2};

    {if4.in_valid, if4.a, if4.b, if4.out_ready}     = '0;
    {if16.in_valid, if16.a, if16.b, if16.out_ready} = '0;
    {if32.in_valid, if32.a, if32.b, if32.out_ready} = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(if16.out_valid), 64'd0);
    chk("rst results", {60'd0, if16.eq, if16.gt, if16.lt, 1'b0} | 64'(if16.depth), 64'd0);
    chk("rst in_ready", {61'd0, if4.in_ready, if16.in_ready, if32.in_ready}, 64'd7);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++)
      txn16(vt[i].nm, vt[i].a, vt[i].b, vt[i].eq, vt[i].gt, vt[i].lt, vt[i].dep, vt[i].lat);

    // Result stall with in_valid toggling on a new pair
    @(negedge clk);
    if16.in_valid  = 1'b1;
    if16.a         = 16'h8000;
    if16.b         = 16'h7FFF;
    if16.out_ready = 1'b0;
    @(posedge clk);
    #1 if16.in_valid = 1'b0;
    wait_res16("stall", 1'b0, 1'b1, 1'b0, 1, 2);
    for (int i = 0; i < 10; i++) begin
      if16.in_valid = (i % 2 == 0);
      if16.a        = 16'h1234;
      if16.b        = 16'h1234;
      @(negedge clk);
      chk("stall hold", {59'd0, if16.out_valid, if16.eq, if16.gt, if16.lt, if16.in_ready},
          {59'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("stall depth", 64'(if16.depth), 64'd1);
    end
    if16.in_valid  = 1'b1;
    if16.out_ready = 1'b1;
    @(negedge clk);
    chk("stall release", {62'd0, if16.out_valid, if16.in_ready}, 64'd1);
    @(posedge clk);
    #1 if16.in_valid = 1'b0;
    wait_res16("post-stall", 1'b1, 1'b0, 1'b0, 4, 5);
    @(negedge clk);
    chk("post-stall drop", 64'(if16.out_valid), 64'd0);

    // Reset in the middle of a compare
    @(negedge clk);
    if16.in_valid = 1'b1;
    if16.a        = 16'h1234;
    if16.b        = 16'h1234;
    @(posedge clk);
    #1 if16.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst outputs", {59'd0, if16.out_valid, if16.eq, if16.gt, if16.lt, 1'b0} | 64'(if16.depth), 64'd0);
    chk("midrst in_ready", 64'(if16.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    txn16("after_rst", 16'h12A4, 16'h12B4, 1'b0, 1'b0, 1'b1, 3, 4);

    // Random pairs with result stalls on the narrow and wide instances
    for (int i = 0; i < 1000; i++)
      rnd4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ra;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) rb[4 * k +: 4] = 4'($urandom_range(0, 15));
      rnd32(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
